// File: rtl/bck_issue_sched_if.sv
// Handshake bundle for the backward-extension issue scheduler:
// read loading, token issue to stage1 and token retirement from the tail.
`ifndef READ_NUM_WIDTH
`define READ_NUM_WIDTH 16
`endif

interface bck_issue_sched_if #(
    parameter int READ_NUM_WIDTH = `READ_NUM_WIDTH,
    parameter int SLOT_W         = 2
);
    logic                      load_valid;
    logic [READ_NUM_WIDTH-1:0] load_read_num;
    logic                      load_ready;
    logic [5:0]                issue_status;
    logic [READ_NUM_WIDTH-1:0] issue_read_num;
    logic [SLOT_W-1:0]         issue_slot;
    logic                      ret_valid;
    logic [SLOT_W-1:0]         ret_slot;
    logic                      ret_done;

    // Environment side: offers reads and retirements, observes tokens.
    modport master (
        output load_valid, load_read_num, ret_valid, ret_slot, ret_done,
        input  load_ready, issue_status, issue_read_num, issue_slot
    );

    // Scheduler side.
    modport slave (
        input  load_valid, load_read_num, ret_valid, ret_slot, ret_done,
        output load_ready, issue_status, issue_read_num, issue_slot
    );
endinterface

// File: rtl/bck_issue_sched.sv
// Round-robin issue scheduler interleaving up to NUM_SLOTS reads into the
// backward-extension pipeline. Emits one registered token per cycle.
`ifndef READ_NUM_WIDTH
`define READ_NUM_WIDTH 16
`endif

module bck_issue_sched #(
    parameter int NUM_SLOTS      = 4,
    parameter int SLOT_W         = 2,
    parameter int READ_NUM_WIDTH = `READ_NUM_WIDTH
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              stall,
    bck_issue_sched_if.slave  bus,
    output logic [SLOT_W:0]   active_cnt,
    output logic              err
);
    localparam int CNT_W = SLOT_W + 1;

    // Token status encodings shared with the pipeline head.
    localparam logic [5:0] BUBBLE  = 6'h00;
    localparam logic [5:0] BCK_INI = 6'h01;
    localparam logic [5:0] BCK_RUN = 6'h02;

    localparam logic [1:0] S_IDLE     = 2'd0;
    localparam logic [1:0] S_PEND_INI = 2'd1;
    localparam logic [1:0] S_INFLIGHT = 2'd2;
    localparam logic [1:0] S_PEND_RUN = 2'd3;

    logic [1:0]                state_q [NUM_SLOTS];
    logic [1:0]                state_d [NUM_SLOTS];
    logic [READ_NUM_WIDTH-1:0] rnum_q  [NUM_SLOTS];
    logic [SLOT_W-1:0]         ptr_q;
    logic                      load_ready_c;
    logic [SLOT_W-1:0]         load_slot;
    logic                      load_acc;
    logic                      grant_vld;
    logic [SLOT_W-1:0]         grant_slot;
    logic [SLOT_W-1:0]         cand;
    logic                      do_grant;
    logic                      ret_err;
    logic [CNT_W-1:0]          cnt_d;

    // Lowest-index idle slot receives the next load (descending scan, last hit wins).
    always_comb begin
        load_ready_c = 1'b0;
        load_slot    = '0;
        for (int unsigned i = NUM_SLOTS; i > 0; i--) begin
            if (state_q[i-1] == S_IDLE) begin
                load_ready_c = 1'b1;
                load_slot    = SLOT_W'(i - 1);
            end
        end
    end

    assign bus.load_ready = load_ready_c;
    assign load_acc       = bus.load_valid & load_ready_c;

    // Round-robin search from the pointer for the first pending slot.
    always_comb begin
        grant_vld  = 1'b0;
        grant_slot = '0;
        cand       = '0;
        for (int unsigned i = 0; i < NUM_SLOTS; i++) begin
            cand = ptr_q + SLOT_W'(i);
            if (!grant_vld &&
                (state_q[cand] == S_PEND_INI || state_q[cand] == S_PEND_RUN)) begin
                grant_vld  = 1'b1;
                grant_slot = cand;
            end
        end
    end

    assign do_grant = grant_vld & ~stall;

    // Per-slot next state, protocol error detection and occupancy count.
    always_comb begin
        ret_err = 1'b0;
        cnt_d   = '0;
        for (int unsigned s = 0; s < NUM_SLOTS; s++) begin
            state_d[s] = state_q[s];
            if (load_acc && load_slot == SLOT_W'(s))
                state_d[s] = S_PEND_INI;
            if (do_grant && grant_slot == SLOT_W'(s))
                state_d[s] = S_INFLIGHT;
            if (bus.ret_valid && bus.ret_slot == SLOT_W'(s)) begin
                if (state_q[s] == S_INFLIGHT)
                    state_d[s] = bus.ret_done ? S_IDLE : S_PEND_RUN;
                else
                    ret_err = 1'b1;
            end
            if (state_d[s] != S_IDLE)
                cnt_d = cnt_d + CNT_W'(1);
        end
    end

    // Slot state, stored read numbers, occupancy and sticky error.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int unsigned i = 0; i < NUM_SLOTS; i++) begin
                state_q[i] <= S_IDLE;
                rnum_q[i]  <= '0;
            end
            active_cnt <= '0;
            err        <= 1'b0;
        end else begin
            state_q    <= state_d;
            active_cnt <= cnt_d;
            if (load_acc)
                rnum_q[load_slot] <= bus.load_read_num;
            if (ret_err)
                err <= 1'b1;
        end
    end

    // Registered issue token and round-robin pointer; both freeze under stall.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            bus.issue_status   <= BUBBLE;
            bus.issue_read_num <= '0;
            bus.issue_slot     <= '0;
            ptr_q              <= '0;
        end else if (!stall) begin
            if (grant_vld) begin
                bus.issue_status   <= (state_q[grant_slot] == S_PEND_INI) ? BCK_INI : BCK_RUN;
                bus.issue_read_num <= rnum_q[grant_slot];
                bus.issue_slot     <= grant_slot;
                ptr_q              <= grant_slot + SLOT_W'(1);
            end else begin
                bus.issue_status   <= BUBBLE;
                bus.issue_read_num <= '0;
                bus.issue_slot     <= '0;
            end
        end
    end
endmodule

// File: doc/bck_issue_sched.md
Name: bck_issue_sched

Overview:
- Round-robin scheduler that interleaves up to NUM_SLOTS independent reads into the backward-extension pipeline (stage1 onward).
- Each cycle it emits one registered status token: BCK_INI, BCK_RUN or BUBBLE, using the pipeline_head.vh encodings.
- A slot is never re-issued while its previous token is still in the pipeline. The pipeline tail reports each token's outcome on the retire port.

Parameters:
- NUM_SLOTS, 4: concurrent read contexts; power of 2, range 2..8.
- SLOT_W, 2: log2(NUM_SLOTS).
- READ_NUM_WIDTH, `READ_NUM_WIDTH: read identifier width.

Ports:
- clk  in  1  pipeline clock
- rst  in  1  asynchronous, active-low reset
- stall  in  1  pipeline stall; freezes the issue outputs and the arbiter
- load_valid  in  1  new read offered for backward extension
- load_read_num  in  READ_NUM_WIDTH  identifier of the offered read
- load_ready  out  1  an idle slot exists; load accepted when valid&ready
- issue_status  out  6  token status to stage1: BCK_INI, BCK_RUN or BUBBLE
- issue_read_num  out  READ_NUM_WIDTH  read number of the token; 0 when BUBBLE
- issue_slot  out  SLOT_W  slot of the token; 0 when BUBBLE
- ret_valid  in  1  pipeline tail retires one token
- ret_slot  in  SLOT_W  slot of the retired token
- ret_done  in  1  with ret_valid: backward loop finished, free the slot
- active_cnt  out  SLOT_W+1  number of non-IDLE slots
- err  out  1  sticky protocol error

Behaviour:
- Reset (rst low, takes effect immediately): issue_status=BUBBLE, issue_read_num=0, issue_slot=0, err=0, active_cnt=0, every slot IDLE, RR pointer=0, load_ready=1.
- Per-slot FSM, states IDLE, PEND_INI, INFLIGHT, PEND_RUN:
  - IDLE -> PEND_INI on accepted load; stores read_num.
  - PEND_INI/PEND_RUN -> INFLIGHT when granted.
  - INFLIGHT -> IDLE on ret_valid with ret_done=1 for this slot.
  - INFLIGHT -> PEND_RUN on ret_valid with ret_done=0 for this slot.
- Load placement: the lowest-index IDLE slot. load_ready is a combinational function of current state only. A slot freed this cycle can be loaded from the next cycle.
- Arbitration, when stall=0:
  - Eligible = slots in PEND_INI or PEND_RUN.
  - Search starts at the RR pointer, ascending, wrapping modulo NUM_SLOTS. The first eligible slot is granted.
  - Pointer becomes grant+1 mod NUM_SLOTS.
  - issue_status is BCK_INI if the granted slot was PEND_INI, else BCK_RUN.
  - Outputs are registered: 1-cycle latency from eligibility to token.
  - No eligible slot: registered BUBBLE with read_num=0, slot=0; pointer unchanged.
- Stall=1: issue outputs hold their values, no grant is made, pointer holds.
- Stall does not block loads or retires; slot state still updates.
- A slot loaded in cycle N is eligible in N+1 and its token appears at N+2 at the earliest.
- A retire-to-PEND_RUN in cycle N allows re-issue the same way, token at N+2 earliest.
- Same-cycle load and retire on different slots: both applied.
- Retire targets only INFLIGHT slots and grants only PEND slots, so the same slot cannot be granted and retired in one cycle.
- ret_valid on a slot not in INFLIGHT: err set sticky until reset; slot state unchanged.
- active_cnt is a registered count of non-IDLE slots, updated the same edge as the states.

Test Plan:
- Reset, then one load (read 5): BUBBLE, then a BCK_INI token for slot0/read5 two cycles after the load. Then ret(slot0, done=0) gives a BCK_RUN token two cycles later; ret(done=1) gives IDLE, active_cnt back to 0, load_ready=1.
- Load reads 1,2,3,4 on consecutive cycles, holding no retires: slots 0..3, four BCK_INI tokens in slot order, then BUBBLEs. load_ready=0 and a fifth load is not accepted.
- All four slots PEND_RUN, pointer=2: grant order is 2,3,0,1 on four consecutive cycles.
- Token for slot1 on issue, stall held 3 cycles while ret(slot0, done=0) arrives: outputs frozen for 3 cycles; slot0 is PEND_RUN on release and issues next.
- ret_valid for an IDLE slot3: err=1 and stays 1; other slots unaffected. Assert rst mid-run: all outputs at reset values immediately, asynchronously.
- Slot0 retires done while a load arrives in the same cycle with slots 1..3 busy: load_ready=0 that cycle; load accepted into slot0 the next cycle.
